// File: rtl/partial_sum_sequencer_pkg.sv
// Shared types and widths for the partial-sum sequencer.
package partial_sum_sequencer_pkg;

    localparam int ACC_W         = 40;
    localparam int TERM_W        = 33;
    localparam int SUM_W         = 41;
    localparam int MAX_TERMS_DEF = 8;
    localparam int CNT_W_DEF     = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/partial_sum_sequencer_if.sv
// Job launch, term stream and result handshake of the partial-sum sequencer.
interface partial_sum_sequencer_if #(
    parameter int CNT_W = 4
);
    import partial_sum_sequencer_pkg::*;

    logic              start;
    logic [ACC_W-1:0]  init_acc;
    logic [CNT_W-1:0]  term_count;
    logic              in_valid;
    logic [TERM_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_sum;
    logic              out_carry;
    logic              out_ready;
    logic              busy;

    modport master (
        output start, init_acc, term_count,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum,
        input  out_carry, busy
    );

    modport slave (
        input  start, init_acc, term_count,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum,
        output out_carry, busy
    );

endinterface

// File: rtl/partial_sum_sequencer_adder.sv
// 40-bit + 33-bit zero-extending ripple adder with a 41-bit sum.
module partial_sum_sequencer_adder
    import partial_sum_sequencer_pkg::*;
(
    input  logic [ACC_W-1:0]  a,
    input  logic [TERM_W-1:0] b,
    output logic [SUM_W-1:0]  sum
);

    logic [ACC_W-1:0] b_ext;
    logic             c;

    assign b_ext = {{(ACC_W-TERM_W){1'b0}}, b};

    always_comb begin
        sum = '0;
        c   = 1'b0;
        for (int i = 0; i < ACC_W; i++) begin
            sum[i] = a[i] ^ b_ext[i] ^ c;
            c      = (a[i] & b_ext[i]) | (c & (a[i] ^ b_ext[i]));
        end
        sum[ACC_W] = c;
    end

endmodule

// File: rtl/partial_sum_sequencer.sv
// Folds a programmed number of 33-bit terms into a 40-bit accumulator
// and hands back the total with a sticky carry-out.
module partial_sum_sequencer
    import partial_sum_sequencer_pkg::*;
#(
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst,
    partial_sum_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t             state;
    state_t             state_n;
    logic [ACC_W-1:0]   acc;
    logic               carry;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   clamped;
    logic [SUM_W-1:0]   sum;
    logic               take;

    partial_sum_sequencer_adder u_adder (
        .a   (acc),
        .b   (bus.in_data),
        .sum (sum)
    );

    assign clamped = (bus.term_count > MAX_CNT) ? MAX_CNT
                                                : bus.term_count;
    assign take    = (state == ACCUM) && bus.in_valid;

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_sum   = acc;
    assign bus.out_carry = carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = (clamped == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (take && remaining == ONE) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Seed on launch, fold one term per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            carry     <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc       <= bus.init_acc;
                        carry     <= 1'b0;
                        remaining <= clamped;
                    end
                end
                ACCUM: begin
                    if (take) begin
                        acc       <= sum[ACC_W-1:0];
                        carry     <= carry | sum[ACC_W];
                        remaining <= remaining - ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/partial_sum_sequencer.md
Name: partial_sum_sequencer

Overview:
Multi-cycle accumulation controller that owns one instance of the team's 40-bit + 33-bit zero-extending ripple adder (41-bit sum). It accepts a programmed number of 33-bit terms over a valid/ready stream and folds each term into a 40-bit running accumulator, one term per cycle. It sits between the partial-product generator of the long-multiply path and the result writeback, and returns the 40-bit total plus a sticky carry-out.

Parameters:
MAX_TERMS, 8, maximum number of terms per job; larger term_count values clamp to this.
CNT_W, 4, width of term_count and of the internal remaining-terms counter; must hold MAX_TERMS.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle job launch; honoured only in IDLE.
init_acc  input  40  accumulator seed, sampled when start is accepted.
term_count  input  CNT_W  number of terms in the job, sampled when start is accepted.
in_valid  input  1  term available.
in_data  input  33  term value, unsigned; the adder zero-extends it to 40 bits.
in_ready  output  1  sequencer can take a term this cycle.
out_valid  output  1  result available.
out_sum  output  40  final accumulator value.
out_carry  output  1  sticky OR of adder bit 40 across the job.
out_ready  input  1  consumer accepts the result.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, carry=0, remaining=0.
- Reset output values: in_ready=0, out_valid=0, out_sum=0, out_carry=0, busy=0.
- Reset mid-job discards the job; no partial result is ever presented.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - On start=1: acc<=init_acc, carry<=0, remaining<=min(term_count, MAX_TERMS).
  - If the clamped count is 0, go to DONE (result = init_acc, carry 0, out_valid on the next cycle).
  - Otherwise go to ACCUM.
- ACCUM:
  - in_ready=1 combinationally in this state only.
  - On in_valid&&in_ready:
    - adder A=acc, B=in_data.
    - acc<=Sum[39:0], so the accumulator wraps modulo 2^40.
    - carry<=carry|Sum[40].
    - remaining<=remaining-1.
  - When the accepted beat has remaining==1, go to DONE.
  - Throughput: 1 term per cycle. Latency: last-term acceptance to out_valid is 1 cycle.
  - in_valid=0 stalls the job indefinitely with no state change.
  - start is ignored in ACCUM.
- DONE:
  - out_valid=1; out_sum=acc and out_carry=carry, both held stable until the handshake.
  - On out_ready=1, return to IDLE the next cycle.
  - start is ignored in DONE, including on the handshake cycle; a new job needs a start in IDLE.
- out_sum and out_carry are driven from the registers in all states. They are only meaningful while out_valid=1; the bench must not check them otherwise.
- The adder path is purely combinational. acc and carry are the only registers in the arithmetic path. No other overflow handling beyond the sticky carry.
- Simultaneous start and rst: rst wins.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ACCUM, DONE);
  - constants ACC_W=40, TERM_W=33, SUM_W=41;
  - MAX_TERMS default.
- One sub-module: the existing 40+33 zero-extending ripple adder, instantiated once with A=acc, B=in_data.
- FSM, counter and handshake logic are inline in this block.

Test Plan:
- Basic sum:
  - Stimulus: init_acc=0, term_count=3, terms 5, 7, 9 back-to-back.
  - Response: out_valid one cycle after the third accept; out_sum=21, out_carry=0; busy low after out_ready.
- Wrap and sticky carry:
  - Stimulus: init_acc=40'hFF_FFFF_FFFF, term_count=2, terms 1 then 2.
  - Response: out_sum=2, out_carry=1.
- Zero count and clamp:
  - Stimulus A: term_count=0, init_acc=40'h12_3456_789A.
  - Response A: DONE reached with no in_ready pulse; out_sum=40'h12_3456_789A, out_carry=0.
  - Stimulus B: term_count=15 with MAX_TERMS=8, ten terms of value 1 offered.
  - Response B: exactly 8 terms accepted; out_sum=8.
- Backpressure:
  - Stimulus: in_valid gaps of 3 idle cycles between terms; out_ready held low for 5 cycles.
  - Response: result unchanged and out_valid held throughout; a start pulsed during DONE is ignored.
- Max operand:
  - Stimulus: init_acc=0, term_count=8, all terms 33'h1_FFFF_FFFF.
  - Response: out_sum=40'h0F_FFFF_FFF8, out_carry=0.
- Async reset mid-job:
  - Stimulus: rst asserted between the 2nd and 3rd term, off the clock edge.
  - Response: immediate IDLE with outputs at reset values; a following fresh job of terms 4, 4 gives out_sum=8.
